// File: rtl/led_array_scan_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_array_scan_master_pkg
// Description : Shared defaults, scan FSM states and row index type for the
//               LED array row scanner.
// Revision    : 1.0
// ============================================================================
package led_array_scan_master_pkg;

    localparam int DEF_ROWS      = 32;
    localparam int DEF_COLS      = 32;
    localparam int DEF_TICK_DIV  = 10;
    localparam int DEF_BLANK_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } scan_state_t;

    typedef logic [$clog2(DEF_ROWS)-1:0] row_idx_t;

endpackage
`default_nettype wire

// File: rtl/led_array_scan_master_if.sv
`default_nettype none
// ============================================================================
// Module      : led_array_scan_master_if
// Description : Control, frame-memory and sub-board signals of the scanner.
// Revision    : 1.0
// ============================================================================
interface led_array_scan_master_if
    import led_array_scan_master_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
);
    localparam int ROW_W = $clog2(ROWS);

    logic             i_EN;
    logic             i_SWAP_REQ;
    logic             o_SWAP_ACK;
    logic             o_BANK;
    logic [ROW_W-1:0] o_RD_ADDR;
    logic [COLS-1:0]  i_RD_DATA;
    logic             o_TOGGLE_SYNC;
    logic             o_HEAD_FLAG;
    logic [COLS-1:0]  o_LED_SRC;
    logic             o_FRAME_START;

    modport master (
        input  i_EN, i_SWAP_REQ, i_RD_DATA,
        output o_SWAP_ACK, o_BANK, o_RD_ADDR, o_TOGGLE_SYNC,
               o_HEAD_FLAG, o_LED_SRC, o_FRAME_START
    );

    modport slave (
        output i_EN, i_SWAP_REQ, i_RD_DATA,
        input  o_SWAP_ACK, o_BANK, o_RD_ADDR, o_TOGGLE_SYNC,
               o_HEAD_FLAG, o_LED_SRC, o_FRAME_START
    );

endinterface
`default_nettype wire

// File: rtl/led_array_scan_master_timer.sv
`default_nettype none
// ============================================================================
// Module      : led_array_scan_master_timer
// Description : Row-slot divider with head-setup, mid-slot, last-cycle and
//               source-enable strobes.
// Revision    : 1.0
// ============================================================================
module led_array_scan_master_timer
    import led_array_scan_master_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    input  wire logic i_clr,
    output logic      o_prime_done,
    output logic      o_mid,
    output logic      o_last,
    output logic      o_src_ok
);
    localparam int DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] w_div_d;

    assign o_prime_done = (r_div_q == DIV_W'(TICK_DIV/2 - 1));
    assign o_mid        = (r_div_q == DIV_W'(TICK_DIV/2));
    assign o_last       = (r_div_q == DIV_W'(TICK_DIV - 1));
    // Source latch is enabled one cycle ahead so the registered word lands
    // exactly when the blanking window ends; never across a slot boundary.
    assign o_src_ok     = (r_div_q >= DIV_W'(BLANK_CYC - 1)) && !o_last;

    always_comb begin
        w_div_d = r_div_q + DIV_W'(1);
        if (i_clr || o_last) begin
            w_div_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_q <= '0;
        end else begin
            r_div_q <= w_div_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_array_scan_master.sv
`default_nettype none
// ============================================================================
// Module      : led_array_scan_master
// Description : Row scanner: toggle-sync/head-flag generation for the sub
//               boards, row fetch from a double-buffered frame memory and
//               blanked column source drive.
// Revision    : 1.0
// ============================================================================
module led_array_scan_master
    import led_array_scan_master_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  wire logic               i_CLK,
    input  wire logic               i_RESET,
    led_array_scan_master_if.master bus
);
    localparam int               ROW_W      = $clog2(ROWS);
    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(ROWS - 1);

    scan_state_t      r_state_q, w_state_d;
    logic [ROW_W-1:0] r_row_q,   w_row_d;
    logic             r_tog_q,   w_tog_d;
    logic             r_head_q,  w_head_d;
    logic             r_bank_q,  w_bank_d;
    logic             r_ack_q,   w_ack_d;
    logic             r_fs_q,    w_fs_d;
    logic [COLS-1:0]  r_src_q,   w_src_d;

    logic w_prime_done;
    logic w_mid;
    logic w_last;
    logic w_src_ok;
    logic w_tmr_clr;

    assign w_tmr_clr = (r_state_q == ST_IDLE) ||
                       ((r_state_q == ST_PRIME) && w_prime_done);

    led_array_scan_master_timer #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .i_clk        (i_CLK),
        .i_rst        (i_RESET),
        .i_clr        (w_tmr_clr),
        .o_prime_done (w_prime_done),
        .o_mid        (w_mid),
        .o_last       (w_last),
        .o_src_ok     (w_src_ok)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_row_d   = r_row_q;
        w_tog_d   = r_tog_q;
        w_head_d  = r_head_q;
        w_bank_d  = r_bank_q;
        w_ack_d   = 1'b0;
        w_fs_d    = 1'b0;
        w_src_d   = '0;

        case (r_state_q)
            ST_IDLE: begin
                w_head_d = 1'b0;
                w_row_d  = '0;
                if (bus.i_EN) begin
                    w_state_d = ST_PRIME;
                    w_head_d  = 1'b1;
                end
            end

            ST_PRIME: begin
                if (w_prime_done) begin
                    w_state_d = ST_RUN;
                    w_tog_d   = ~r_tog_q;
                    w_row_d   = '0;
                    w_fs_d    = 1'b1;
                end
            end

            ST_RUN: begin
                if (w_src_ok) begin
                    w_src_d = bus.i_RD_DATA;
                end
                // Head only moves mid-slot so it is stable around every edge.
                if (w_mid) begin
                    w_head_d = (r_row_q == C_LAST_ROW);
                end
                if (w_last) begin
                    if (r_row_q != C_LAST_ROW) begin
                        w_row_d = r_row_q + ROW_W'(1);
                        w_tog_d = ~r_tog_q;
                    end else begin
                        if (bus.i_SWAP_REQ) begin
                            w_bank_d = ~r_bank_q;
                            w_ack_d  = 1'b1;
                        end
                        w_row_d = '0;
                        if (bus.i_EN) begin
                            w_tog_d = ~r_tog_q;
                            w_fs_d  = 1'b1;
                        end else begin
                            w_state_d = ST_IDLE;
                            w_head_d  = 1'b0;
                        end
                    end
                end
            end

            default: begin
                w_state_d = ST_IDLE;
                w_head_d  = 1'b0;
                w_row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state_q <= ST_IDLE;
            r_row_q   <= '0;
            r_tog_q   <= 1'b0;
            r_head_q  <= 1'b0;
            r_bank_q  <= 1'b0;
            r_ack_q   <= 1'b0;
            r_fs_q    <= 1'b0;
            r_src_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_row_q   <= w_row_d;
            r_tog_q   <= w_tog_d;
            r_head_q  <= w_head_d;
            r_bank_q  <= w_bank_d;
            r_ack_q   <= w_ack_d;
            r_fs_q    <= w_fs_d;
            r_src_q   <= w_src_d;
        end
    end

    assign bus.o_SWAP_ACK    = r_ack_q;
    assign bus.o_BANK        = r_bank_q;
    assign bus.o_RD_ADDR     = r_row_q;
    assign bus.o_TOGGLE_SYNC = r_tog_q;
    assign bus.o_HEAD_FLAG   = r_head_q;
    assign bus.o_LED_SRC     = r_src_q;
    assign bus.o_FRAME_START = r_fs_q;

endmodule
`default_nettype wire

// File: tb/tb_led_array_scan_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_array_scan_master
// Description : Self-checking bench: slot-time reference model, frame memory
//               and sub-board sink counter against the row scanner.
// Revision    : 1.0
// ============================================================================
module tb_led_array_scan_master;

    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int TD    = 8;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic swap = 1'b0;

    always #5 clk = ~clk;

    led_array_scan_master_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    led_array_scan_master #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .TICK_DIV  (TD),
        .BLANK_CYC (BLANK)
    ) dut (
        .i_CLK   (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    assign bus.i_EN       = en;
    assign bus.i_SWAP_REQ = swap;

    // Frame memory with one-cycle read latency
    logic [COLS-1:0] mem [2][ROWS];
    always @(posedge clk) bus.i_RD_DATA <= mem[bus.o_BANK][bus.o_RD_ADDR];

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 head setup, 2 scanning.
    // m_t counts cycles since the row-0 edge of the current frame.
    int m_mode = 0;
    int m_pc   = 0;
    int m_t    = 0;
    int m_bank = 0;
    int m_tog  = 0;
    int m_ack  = 0;
    int m_rst  = 0;

    int sink = 0;
    bit sink_valid = 1'b0;
    bit prev_tog = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_ack = 0;
        m_rst = 0;
        if (rst) begin
            m_mode = 0; m_tog = 0; m_bank = 0; m_t = 0; m_pc = 0; m_rst = 1;
        end else begin
            case (m_mode)
                0: if (en) begin m_mode = 1; m_pc = 0; end
                1: begin
                    m_pc++;
                    if (m_pc == TD/2) begin m_mode = 2; m_t = 0; m_tog ^= 1; end
                end
                default: begin
                    m_t++;
                    if (m_t == TD*ROWS) begin
                        if (swap) begin m_bank ^= 1; m_ack = 1; end
                        if (en) begin m_t = 0; m_tog ^= 1; end
                        else m_mode = 0;
                    end else if (m_t % TD == 0) begin
                        m_tog ^= 1;
                    end
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        int slot, ph;
        logic [31:0] e_head, e_src, e_addr, e_fs;
        e_head = 0; e_src = 0; e_addr = 0; e_fs = 0;
        if (m_mode == 2) begin
            slot   = m_t / TD;
            ph     = m_t % TD;
            e_addr = slot;
            e_src  = (ph < BLANK) ? 32'd0 : 32'(mem[m_bank][slot]);
            e_fs   = (m_t == 0) ? 1 : 0;
            e_head = ((slot == 0 && ph <= TD/2) || (slot == ROWS-1 && ph > TD/2)) ? 1 : 0;
        end else if (m_mode == 1) begin
            e_head = 1;
        end
        chk("toggle",      32'(bus.o_TOGGLE_SYNC), 32'(m_tog));
        chk("head",        32'(bus.o_HEAD_FLAG),   e_head);
        chk("rd_addr",     32'(bus.o_RD_ADDR),     e_addr);
        chk("led_src",     32'(bus.o_LED_SRC),     e_src);
        chk("frame_start", 32'(bus.o_FRAME_START), e_fs);
        chk("swap_ack",    32'(bus.o_SWAP_ACK),    32'(m_ack));
        chk("bank",        32'(bus.o_BANK),        32'(m_bank));

        // Sub-board one-hot sink decoder modelled as a dual-edge counter
        if (m_rst != 0) sink_valid = 1'b0;
        if (bus.o_TOGGLE_SYNC !== prev_tog) begin
            if (bus.o_HEAD_FLAG) begin sink = 0; sink_valid = 1'b1; end
            else sink = (sink + 1) % ROWS;
        end
        prev_tog = bus.o_TOGGLE_SYNC;
        if (m_mode == 2 && sink_valid) chk("sink", 32'(sink), e_addr);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        // Writer refills the bank that just left the display
        if (m_ack != 0) begin
            for (int r = 0; r < ROWS; r++) mem[m_bank ^ 1][r] = COLS'($urandom);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_slot(input int row, input int ph);
        int n;
        for (n = 0; n < 4*TD*ROWS; n++) begin
            if (m_mode == 2 && m_t / TD == row && m_t % TD == ph) break;
            step();
        end
        if (n == 4*TD*ROWS) begin
            checks++;
            errors++;
            $error("FAIL wait_slot timeout: row %0d phase %0d not reached", row, ph);
        end
    endtask

    task automatic wait_ack();
        int n;
        for (n = 0; n < 2*TD*ROWS; n++) begin
            step();
            if (m_ack != 0) break;
        end
        chk("ack_seen", 32'(m_ack), 32'd1);
    endtask

    initial begin
        mem[0][0] = 8'h01; mem[0][1] = 8'h02; mem[0][2] = 8'h04; mem[0][3] = 8'h08;
        for (int r = 0; r < ROWS; r++) mem[1][r] = COLS'($urandom);

        // Reset state
        rst = 1'b1; en = 1'b0; swap = 1'b0;
        run(3);
        rst = 1'b0;
        run(2);

        // Start-up, edge spacing, blanking, head across row-0 edges
        en = 1'b1;
        run(TD*ROWS*2 + 6);

        // Swap request raised mid row 1, held across two boundaries, then dropped
        wait_slot(1, 3);
        swap = 1'b1;
        wait_ack();
        wait_ack();
        swap = 1'b0;
        run(TD*ROWS + 4);

        // Enable dropped in row 1: frame completes, then idle with static toggle
        wait_slot(1, 2);
        en = 1'b0;
        run(TD*ROWS*2);

        // Reset in row 2 aborts immediately
        en = 1'b1;
        wait_slot(2, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        en = 1'b0;
        run(6);

        // Swap and enable drop at the same boundary
        en = 1'b1;
        wait_slot(2, 2);
        swap = 1'b1;
        en = 1'b0;
        run(TD*ROWS);
        swap = 1'b0;
        run(10);

        // Randomized enable/swap/reset activity
        en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) swap = ~swap;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
